// File: rtl/fake_psx_pad_pkg.sv
// psx_defs: shared definitions for the fake PlayStation digital pad.
//   - psx_state_t   : protocol FSM states
//   - protocol bytes: START_CMD, BEGIN_TX_CMD, PREAMBLE, DIGITAL_ID, IDLE_BYTE
//   - response_byte : byte the pad shifts out at a given position in the frame
package psx_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_DONE
    } psx_state_t;

    localparam logic [7:0] START_CMD    = 8'h01;
    localparam logic [7:0] BEGIN_TX_CMD = 8'h42;
    localparam logic [7:0] PREAMBLE     = 8'h5A;
    localparam logic [7:0] DIGITAL_ID   = 8'h41;
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;

    // Index of the final byte of a digital-pad poll (never acknowledged)
    localparam logic [2:0] LAST_BYTE_IDX = 3'd4;
    // byte_idx saturates here
    localparam logic [2:0] BYTE_IDX_MAX  = 3'd5;

    // Response byte for frame position idx; buttons are active-low, bit0 first.
    function automatic logic [7:0] response_byte(
        input logic [2:0]  idx,
        input logic [7:0]  pad_id,
        input logic [15:0] btn
    );
        logic [7:0] r;
        case (idx)
            3'd1:    r = pad_id;
            3'd2:    r = PREAMBLE;
            3'd3:    r = btn[7:0];
            3'd4:    r = btn[15:8];
            default: r = IDLE_BYTE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fake_psx_pad_sync_edge.sv
// psx_sync_edge: two-flop synchronizer for an asynchronous console line plus
// single-cycle rise/fall strobes derived from the synchronized copy.
// Everything runs on the falling edge of clk; flops preset to 1 (idle-high bus).
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   async_in in  raw console line
//   sync_out out synchronized level
//   rise     out one-cycle strobe on synchronized 0->1
//   fall     out one-cycle strobe on synchronized 1->0
module psx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/fake_psx_pad.sv
// fake_psx_pad: emulates a PlayStation digital controller on the console's
// serial bus. Receives command bytes LSB first, answers FF / ID / 5A / buttons,
// and acknowledges bytes 0-3 with a delayed active-low ack pulse.
// All logic is clocked on the falling edge of clk.
//   clk        in   system clock (500 ns period)
//   rst_n      in   asynchronous active-low reset
//   psx_clk    in   console serial clock, idle high, asynchronous
//   cmd        in   console command line, asynchronous
//   att        in   console attention, active-low frame select, asynchronous
//   buttons    in   button states, active-low, bit0 transmitted first
//   data       out  response line, idle high
//   ack        out  active-low acknowledge pulse
//   cmd_byte   out  last fully received command byte
//   byte_valid out  one-cycle strobe when cmd_byte updates
//   err        out  sticky: first byte of frame was not START_CMD
module fake_psx_pad
    import psx_defs::*;
#(
    parameter int         ACK_DELAY = 12,
    parameter int         ACK_WIDTH = 4,
    parameter logic [7:0] PAD_ID    = DIGITAL_ID
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic [7:0]  cmd_byte,
    output logic        byte_valid,
    output logic        err
);

    localparam int DLY_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int DLY_W   = (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0] WAIT_LAST  = DLY_W'(ACK_DELAY - 1);
    localparam logic [DLY_W-1:0] PULSE_LAST = DLY_W'(ACK_WIDTH - 1);

    psx_state_t state_q;
    psx_state_t state_d;

    logic             psx_lvl;
    logic             psx_rise;
    logic             psx_fall;
    logic             att_lvl;
    logic             att_rise;
    logic             att_fall;
    logic             cmd_meta;
    logic             cmd_sync;

    logic [2:0]       bit_cnt;
    logic [2:0]       byte_idx;
    logic [6:0]       rx_q;
    logic [7:0]       rx_full;
    logic [7:0]       tx_q;
    logic             data_q;
    logic [15:0]      btn_q;
    logic [DLY_W-1:0] dly_cnt;
    logic [1:0]       settle;
    logic             armed;
    logic             byte_done;

    psx_sync_edge u_psx_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (psx_clk),
        .sync_out (psx_lvl),
        .rise     (psx_rise),
        .fall     (psx_fall)
    );

    psx_sync_edge u_att_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (att),
        .sync_out (att_lvl),
        .rise     (att_rise),
        .fall     (att_fall)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_meta <= 1'b1;
            cmd_sync <= 1'b1;
        end else begin
            cmd_meta <= cmd;
            cmd_sync <= cmd_meta;
        end
    end

    // Received bits shift in from the top, so after seven rises rx_q holds
    // bits 6..0 and the eighth bit completes the byte combinationally.
    assign rx_full   = {cmd_sync, rx_q};
    assign byte_done = (state_q == ST_SHIFT) && psx_rise && (bit_cnt == 3'd7);

    // State register
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; attention release overrides every bus event
    always_comb begin
        state_d = state_q;
        if (att_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (att_fall && armed) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (byte_done) begin
                        if (byte_idx == 3'd0 && rx_full != START_CMD)
                            state_d = ST_DONE;
                        else if (byte_idx == 3'd1 && rx_full != BEGIN_TX_CMD)
                            state_d = ST_DONE;
                        else if (byte_idx >= LAST_BYTE_IDX)
                            state_d = ST_DONE;
                        else
                            state_d = ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (psx_fall)                  state_d = ST_SHIFT;
                    else if (dly_cnt == WAIT_LAST) state_d = ST_ACK_PULSE;
                end
                ST_ACK_PULSE: begin
                    if (psx_fall)                   state_d = ST_SHIFT;
                    else if (dly_cnt == PULSE_LAST) state_d = ST_SHIFT;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        data = 1'b1;
        ack  = 1'b1;
        case (state_q)
            ST_SHIFT, ST_ACK_WAIT: data = data_q;
            ST_ACK_PULSE: begin
                data = data_q;
                ack  = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath: bit/byte counters, shift registers, ack timing, strobes
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            byte_idx   <= '0;
            rx_q       <= '0;
            tx_q       <= IDLE_BYTE;
            data_q     <= 1'b1;
            btn_q      <= '1;
            dly_cnt    <= '0;
            settle     <= '0;
            armed      <= 1'b0;
            cmd_byte   <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            settle     <= {settle[0], 1'b1};

            // Synchronizers are preset high, so a line held low through reset
            // shows up as a false fall; arm only once the flushed bus is idle.
            if (settle[1] && att_lvl && psx_lvl)
                armed <= 1'b1;

            if (state_d == state_q &&
                (state_q == ST_ACK_WAIT || state_q == ST_ACK_PULSE))
                dly_cnt <= dly_cnt + DLY_W'(1);
            else
                dly_cnt <= '0;

            if (att_rise) begin
                bit_cnt <= '0;
            end else if (state_q == ST_IDLE) begin
                if (att_fall && armed) begin
                    bit_cnt  <= '0;
                    byte_idx <= '0;
                    err      <= 1'b0;
                    tx_q     <= IDLE_BYTE;
                    data_q   <= 1'b1;
                end
            end else if (state_q != ST_DONE) begin
                if (psx_fall)
                    data_q <= tx_q[bit_cnt];
                if (state_q == ST_SHIFT && psx_rise) begin
                    rx_q    <= {cmd_sync, rx_q[6:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        cmd_byte   <= rx_full;
                        byte_valid <= 1'b1;
                        byte_idx   <= (byte_idx == BYTE_IDX_MAX) ? byte_idx
                                                                 : byte_idx + 3'd1;
                        if (byte_idx == 3'd0 && rx_full != START_CMD)
                            err <= 1'b1;
                        if (byte_idx == 3'd2)
                            btn_q <= buttons;
                        // Byte 3 is loaded from the live buttons in the same
                        // cycle they are latched for byte 4.
                        tx_q <= response_byte(byte_idx + 3'd1, PAD_ID,
                                              (byte_idx == 3'd2) ? buttons : btn_q);
                    end
                end
            end
        end
    end

endmodule
